nexys_starship_monster_ctrl: RTL and testbench
==============================================

Name: nexys_starship_monster_ctrl

Overview:
- Consumes the per-side spawn bits from the starship PRNG: top_random, btm_random, left_random, right_random.
- Maintains one alien "lane" per side: spawn, lifetime countdown, shoot-down, cooldown.
- Tracks score and lives, and runs the top-level game state (IDLE/PLAY/OVER).
- Outputs feed the VGA renderer and the SSD score display.

Parameters:
- LIFETIME, 8: ticks an alien survives before it damages the ship (legal 2..15).
- COOLDOWN, 2: ticks a lane stays blocked after a kill or expiry (legal 1..15).
- LIVES, 3: starting lives (legal 1..3).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- tick  in  1  one-Clk-wide game-time enable, nominally ~1 Hz
- start  in  1  one-Clk pulse from debounced centre button
- spawn_req  in  4  {right_random, left_random, btm_random, top_random}; bit0=top, 1=btm, 2=left, 3=right
- shoot  in  4  one-Clk pulses from debounced direction buttons, same bit order as spawn_req
- alien  out  4  lane i currently ALIVE
- score  out  8  kills this game, saturating
- lives  out  2  remaining lives
- game_state  out  2  0=IDLE, 1=PLAY, 2=OVER
- hit  out  1  one-Clk pulse on any kill
- miss  out  1  one-Clk pulse on any expiry

Behaviour:
- All state updates on posedge Clk. Reset is synchronous, active-high, and overrides every other input.
- Reset values: game_state=IDLE, all lanes EMPTY (timer=0), alien=0, score=0, lives=LIVES, hit=0, miss=0.
- All outputs are registered: an event sampled in cycle N is visible in cycle N+1.
- Game FSM:
  - IDLE --start--> PLAY.
  - PLAY --(lives==0)--> OVER.
  - OVER --start--> PLAY.
  - On entering PLAY: score=0, lives=LIVES, all lanes EMPTY.
  - start is ignored while in PLAY.
- Lane FSM (4 identical copies, 4-bit timer each). Lanes only change in PLAY; in IDLE and OVER all lanes are held EMPTY.
  - EMPTY: on tick with spawn_req[i]=1 -> ALIVE, timer=LIFETIME.
  - ALIVE, shoot[i]=1 (any cycle, tick not required) -> COOLDOWN, timer=COOLDOWN; contributes +1 kill.
  - ALIVE, tick, timer==1 -> COOLDOWN, timer=COOLDOWN; contributes one expiry.
  - ALIVE, tick, timer>1 -> timer-1.
  - COOLDOWN: on tick, if timer==1 -> EMPTY, else timer-1. spawn_req is ignored in this state.
  - shoot[i] on an EMPTY or COOLDOWN lane has no effect: no score, no penalty.
- Simultaneous events:
  - shoot[i] and expiry of the same lane in the same cycle: the shoot wins (kill, no life lost).
  - Several lanes may spawn, die, or expire in the same cycle; counts are summed.
- Arithmetic:
  - score += number of kills this cycle (0..4), saturating at 255.
  - lives -= number of expiries this cycle, saturating at 0.
  - hit=1 iff kills>0; miss=1 iff expiries>0.
- Game over:
  - When lives reaches 0, game_state becomes OVER in the following cycle and all lanes clear to EMPTY.
  - score is frozen in OVER.
- alien[i] = (lane i is ALIVE).
- tick is level-sampled: a tick held high for k cycles counts as k ticks. The upstream divider guarantees single-cycle ticks.
- Reset asserted mid-game returns everything to the reset values on that clock edge.

Test Plan:
- Reset, start, then tick with spawn_req=4'b0001 -> alien=4'b0001 next cycle; with no further spawns and 8 ticks, miss pulses once, lives=2, alien=0.
- Alien in lane 2 at timer=3; pulse shoot=4'b0100 between ticks -> alien[2]=0, hit=1 for exactly 1 cycle, score=1. The same lane then ignores spawn_req for 2 ticks and respawns on the 3rd tick.
- Aliens in lanes 0 and 3, both at timer=1; on a tick, also pulse shoot=4'b1000 -> score+1, lives-1, hit=1 and miss=1 in the same cycle.
- LIVES=3 with lanes 0, 1 and 2 all expiring on one tick -> lives=0, game_state=OVER one cycle later, alien=0. Then pulse start -> PLAY, score=0, lives=3.
- Preload score=254, then kill 4 lanes in one cycle -> score=255 (saturated). Shoot on an EMPTY lane -> score and lives unchanged.
- Assert Reset mid-PLAY with alien=4'b1111 -> on the next edge game_state=IDLE, alien=0, score=0, lives=3; start and tick are ignored while Reset is high.

Source files
------------

// File: rtl/nexys_starship_monster_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : nexys_starship_monster_ctrl
//  Purpose  : Alien lane control, score/lives bookkeeping and top-level game
//             state for the Nexys starship game. Four lanes (top, btm, left,
//             right) each spawn an alien on a game tick, count down its
//             lifetime, and enter a cooldown after a kill or an expiry.
//  Ports    : Clk        - system clock
//             Reset      - synchronous active-high reset
//             tick       - one-Clk game-time enable
//             start      - one-Clk pulse, starts or restarts a game
//             spawn_req  - per-lane spawn bits {right, left, btm, top}
//             shoot      - per-lane one-Clk shoot pulses, same order
//             alien      - lane i currently has a live alien
//             score      - kills this game, saturating at 255
//             lives      - remaining lives
//             game_state - 0=IDLE, 1=PLAY, 2=OVER
//             hit / miss - one-Clk pulses on any kill / any expiry
//  Revision : 1.0 - initial release
// ============================================================================
module nexys_starship_monster_ctrl #(
    parameter int LIFETIME = 8,
    parameter int COOLDOWN = 2,
    parameter int LIVES    = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] spawn_req,
    input  logic [3:0] shoot,
    output logic [3:0] alien,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [1:0] game_state,
    output logic       hit,
    output logic       miss
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_PLAY   = 2'd1;
    localparam logic [1:0] c_ST_OVER   = 2'd2;

    localparam logic [1:0] c_LN_EMPTY  = 2'd0;
    localparam logic [1:0] c_LN_ALIVE  = 2'd1;
    localparam logic [1:0] c_LN_COOL   = 2'd2;

    localparam logic [3:0] c_LIFETIME  = 4'(LIFETIME);
    localparam logic [3:0] c_COOLDOWN  = 4'(COOLDOWN);
    localparam logic [1:0] c_LIVES     = 2'(LIVES);

    logic [1:0] r_state;
    logic [1:0] r_lane_st  [4];
    logic [3:0] r_lane_tmr [4];
    logic [3:0] r_alien;
    logic [7:0] r_score;
    logic [1:0] r_lives;
    logic       r_hit;
    logic       r_miss;

    logic [1:0] w_lane_st_nxt  [4];
    logic [3:0] w_lane_tmr_nxt [4];
    logic [3:0] w_alien_nxt;
    logic [3:0] w_kill;
    logic [3:0] w_expire;
    logic [2:0] w_kill_cnt;
    logic [2:0] w_expire_cnt;
    logic [8:0] w_score_sum;
    logic [7:0] w_score_nxt;
    logic [1:0] w_lives_nxt;

    // Per-lane next state while playing. A shoot is checked before the
    // lifetime countdown so that a shot landing on the expiry tick wins.
    always_comb begin
        w_kill       = '0;
        w_expire     = '0;
        w_alien_nxt  = '0;
        w_kill_cnt   = '0;
        w_expire_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            w_lane_st_nxt[i]  = r_lane_st[i];
            w_lane_tmr_nxt[i] = r_lane_tmr[i];
            case (r_lane_st[i])
                c_LN_EMPTY: begin
                    if (tick && spawn_req[i]) begin
                        w_lane_st_nxt[i]  = c_LN_ALIVE;
                        w_lane_tmr_nxt[i] = c_LIFETIME;
                    end
                end
                c_LN_ALIVE: begin
                    if (shoot[i]) begin
                        w_kill[i]         = 1'b1;
                        w_lane_st_nxt[i]  = c_LN_COOL;
                        w_lane_tmr_nxt[i] = c_COOLDOWN;
                    end else if (tick) begin
                        if (r_lane_tmr[i] == 4'd1) begin
                            w_expire[i]       = 1'b1;
                            w_lane_st_nxt[i]  = c_LN_COOL;
                            w_lane_tmr_nxt[i] = c_COOLDOWN;
                        end else begin
                            w_lane_tmr_nxt[i] = r_lane_tmr[i] - 4'd1;
                        end
                    end
                end
                c_LN_COOL: begin
                    if (tick) begin
                        if (r_lane_tmr[i] == 4'd1) begin
                            w_lane_st_nxt[i]  = c_LN_EMPTY;
                            w_lane_tmr_nxt[i] = 4'd0;
                        end else begin
                            w_lane_tmr_nxt[i] = r_lane_tmr[i] - 4'd1;
                        end
                    end
                end
                default: begin
                    w_lane_st_nxt[i]  = c_LN_EMPTY;
                    w_lane_tmr_nxt[i] = 4'd0;
                end
            endcase
            w_alien_nxt[i] = (w_lane_st_nxt[i] == c_LN_ALIVE);
            w_kill_cnt     = w_kill_cnt + {2'b00, w_kill[i]};
            w_expire_cnt   = w_expire_cnt + {2'b00, w_expire[i]};
        end

        // Score saturates at 255; the carry bit flags the overflow.
        w_score_sum = {1'b0, r_score} + {6'd0, w_kill_cnt};
        w_score_nxt = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

        // Lives floor at zero even if several lanes expire at once.
        if ({1'b0, r_lives} <= w_expire_cnt) begin
            w_lives_nxt = 2'd0;
        end else begin
            w_lives_nxt = r_lives - w_expire_cnt[1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                r_lane_st[i]  <= c_LN_EMPTY;
                r_lane_tmr[i] <= 4'd0;
            end
            r_alien <= '0;
            r_score <= '0;
            r_lives <= c_LIVES;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_PLAY: begin
                    if (r_lives == 2'd0) begin
                        // Lives ran out on the previous edge: freeze score,
                        // clear the field.
                        r_state <= c_ST_OVER;
                        for (int i = 0; i < 4; i++) begin
                            r_lane_st[i]  <= c_LN_EMPTY;
                            r_lane_tmr[i] <= 4'd0;
                        end
                        r_alien <= '0;
                        r_hit   <= 1'b0;
                        r_miss  <= 1'b0;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            r_lane_st[i]  <= w_lane_st_nxt[i];
                            r_lane_tmr[i] <= w_lane_tmr_nxt[i];
                        end
                        r_alien <= w_alien_nxt;
                        r_score <= w_score_nxt;
                        r_lives <= w_lives_nxt;
                        r_hit   <= |w_kill;
                        r_miss  <= |w_expire;
                    end
                end
                default: begin
                    // IDLE and OVER hold the field empty and wait for start.
                    for (int i = 0; i < 4; i++) begin
                        r_lane_st[i]  <= c_LN_EMPTY;
                        r_lane_tmr[i] <= 4'd0;
                    end
                    r_alien <= '0;
                    r_hit   <= 1'b0;
                    r_miss  <= 1'b0;
                    if (r_state != c_ST_IDLE && r_state != c_ST_OVER) begin
                        r_state <= c_ST_IDLE;
                    end else if (start) begin
                        r_state <= c_ST_PLAY;
                        r_score <= '0;
                        r_lives <= c_LIVES;
                    end
                end
            endcase
        end
    end

    assign alien      = r_alien;
    assign score      = r_score;
    assign lives      = r_lives;
    assign game_state = r_state;
    assign hit        = r_hit;
    assign miss       = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_nexys_starship_monster_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_nexys_starship_monster_ctrl
//  Purpose  : Directed, table-driven bench for nexys_starship_monster_ctrl
//             with hand-written sequences for game over, score saturation
//             and mid-game reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nexys_starship_monster_ctrl;

    logic       Clk;
    logic       Reset;
    logic       tick;
    logic       start;
    logic [3:0] spawn_req;
    logic [3:0] shoot;
    logic [3:0] alien;
    logic [7:0] score;
    logic [1:0] lives;
    logic [1:0] game_state;
    logic       hit;
    logic       miss;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       t;
        logic       st;
        logic [3:0] sp;
        logic [3:0] sh;
        logic [3:0] e_alien;
        logic [7:0] e_score;
        logic [1:0] e_lives;
        logic [1:0] e_state;
        logic       e_hit;
        logic       e_miss;
    } vec_t;

    vec_t tbl[$];

    nexys_starship_monster_ctrl #(
        .LIFETIME (8),
        .COOLDOWN (2),
        .LIVES    (3)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .tick       (tick),
        .start      (start),
        .spawn_req  (spawn_req),
        .shoot      (shoot),
        .alien      (alien),
        .score      (score),
        .lives      (lives),
        .game_state (game_state),
        .hit        (hit),
        .miss       (miss)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic t, input logic st,
                                input logic [3:0] sp, input logic [3:0] sh,
                                input logic [3:0] al, input logic [7:0] sc,
                                input logic [1:0] lv, input logic [1:0] gs,
                                input logic h, input logic m);
        vec_t v;
        v.t = t; v.st = st; v.sp = sp; v.sh = sh;
        v.e_alien = al; v.e_score = sc; v.e_lives = lv; v.e_state = gs;
        v.e_hit = h; v.e_miss = m;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input logic [3:0] al,
                           input logic [7:0] sc, input logic [1:0] lv,
                           input logic [1:0] gs, input logic h, input logic m);
        chk({nm, " alien"}, int'(alien), int'(al));
        chk({nm, " score"}, int'(score), int'(sc));
        chk({nm, " lives"}, int'(lives), int'(lv));
        chk({nm, " state"}, int'(game_state), int'(gs));
        chk({nm, " hit"},   int'(hit), int'(h));
        chk({nm, " miss"},  int'(miss), int'(m));
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic t, input logic st,
                       input logic [3:0] sp, input logic [3:0] sh);
        tick = t; start = st; spawn_req = sp; shoot = sh;
        @(posedge Clk);
        #1;
        tick = 1'b0; start = 1'b0; spawn_req = 4'd0; shoot = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; tick = 1'b1; start = 1'b1;
        spawn_req = 4'hF; shoot = 4'hF;

        // Basic expiry, kill, cooldown, simultaneous hit+miss.
        tbl.push_back(mk(0,1,4'b0000,4'b0000, 4'b0000,0,3,1,0,0));
        tbl.push_back(mk(1,0,4'b0001,4'b0000, 4'b0001,0,3,1,0,0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1,0,0,0, 4'b0001,0,3,1,0,0));
        tbl.push_back(mk(1,0,0,0, 4'b0000,0,2,1,0,1));
        tbl.push_back(mk(0,0,0,0, 4'b0000,0,2,1,0,0));
        tbl.push_back(mk(1,0,4'b0100,0, 4'b0100,0,2,1,0,0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1,0,0,0, 4'b0100,0,2,1,0,0));
        tbl.push_back(mk(0,0,0,4'b0100, 4'b0000,1,2,1,1,0));
        tbl.push_back(mk(0,0,0,0, 4'b0000,1,2,1,0,0));
        tbl.push_back(mk(0,1,0,0, 4'b0000,1,2,1,0,0));
        tbl.push_back(mk(0,0,0,4'b0100, 4'b0000,1,2,1,0,0));
        tbl.push_back(mk(1,0,4'b0100,0, 4'b0000,1,2,1,0,0));
        tbl.push_back(mk(1,0,4'b0100,0, 4'b0000,1,2,1,0,0));
        tbl.push_back(mk(1,0,4'b0100,0, 4'b0100,1,2,1,0,0));
        tbl.push_back(mk(0,0,0,4'b0100, 4'b0000,2,2,1,1,0));
        tbl.push_back(mk(1,0,4'b1001,0, 4'b1001,2,2,1,0,0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1,0,0,0, 4'b1001,2,2,1,0,0));
        tbl.push_back(mk(1,0,0,4'b1000, 4'b0000,3,1,1,1,1));
        tbl.push_back(mk(0,0,0,0, 4'b0000,3,1,1,0,0));

        // Reset state, with start/tick held high to show they are ignored.
        repeat (3) @(posedge Clk);
        #1;
        chk_all("reset", 4'b0000, 0, 3, 0, 0, 0);
        Reset = 1'b0; tick = 1'b0; start = 1'b0; spawn_req = 4'd0; shoot = 4'd0;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].t, tbl[i].st, tbl[i].sp, tbl[i].sh);
            chk_all($sformatf("v%0d", i), tbl[i].e_alien, tbl[i].e_score,
                    tbl[i].e_lives, tbl[i].e_state, tbl[i].e_hit, tbl[i].e_miss);
        end

        // Three lanes expire with one life left: lives floor at 0, then OVER.
        cyc(1, 0, 4'b0111, 0);
        repeat (7) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_all("go1 expire", 4'b0000, 3, 0, 1, 0, 1);
        cyc(0, 0, 0, 0);
        chk_all("go1 over", 4'b0000, 3, 0, 2, 0, 0);
        cyc(1, 0, 4'b1111, 4'b1111);
        chk_all("go1 frozen", 4'b0000, 3, 0, 2, 0, 0);
        cyc(0, 1, 0, 0);
        chk_all("go1 restart", 4'b0000, 0, 3, 1, 0, 0);

        // Full lives lost in one tick.
        cyc(1, 0, 4'b0111, 0);
        chk("go2 spawn alien", int'(alien), 7);
        repeat (7) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_all("go2 expire", 4'b0000, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0);
        chk_all("go2 over", 4'b0000, 0, 0, 2, 0, 0);
        cyc(0, 1, 0, 0);
        chk_all("go2 restart", 4'b0000, 0, 3, 1, 0, 0);

        // Build the score to 252 with four kills per round.
        for (int r = 0; r < 63; r++) begin
            cyc(1, 0, 4'b1111, 0);
            cyc(0, 0, 0, 4'b1111);
            cyc(1, 0, 0, 0);
            cyc(1, 0, 0, 0);
        end
        chk("sat build 252", int'(score), 252);
        cyc(1, 0, 4'b1111, 0);
        cyc(0, 0, 0, 4'b0011);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 4'b0011, 0);
        chk_all("sat pre", 4'b1111, 254, 3, 1, 0, 0);
        cyc(0, 0, 0, 4'b1111);
        chk_all("sat kill4", 4'b0000, 255, 3, 1, 1, 0);
        cyc(0, 0, 0, 4'b0001);
        chk_all("shoot empty", 4'b0000, 255, 3, 1, 0, 0);

        // Reset in the middle of play with every lane alive.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 4'b1111, 0);
        chk_all("rst pre", 4'b1111, 255, 3, 1, 0, 0);
        Reset = 1'b1;
        cyc(1, 1, 4'b1111, 0);
        chk_all("rst mid", 4'b0000, 0, 3, 0, 0, 0);
        cyc(1, 1, 4'b1111, 0);
        chk_all("rst held", 4'b0000, 0, 3, 0, 0, 0);
        Reset = 1'b0;
        cyc(0, 0, 0, 0);
        chk_all("rst release", 4'b0000, 0, 3, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
